// File: rtl/avoid_sequencer_pkg.sv
// avoid_sequencer_pkg: shared motor codes, state encoding and parameter defaults for the avoidance sequencer
package avoid_sequencer_pkg;
  localparam int DEB_N_DEF     = 3;
  localparam int STOP_T_DEF    = 2;
  localparam int TURN_T_DEF    = 4;
  localparam int PASS_T_DEF    = 5;
  localparam int MAX_RETRY_DEF = 2;
  localparam int TW            = 8;
  localparam logic [1:0] D_STOP  = 2'b00;
  localparam logic [1:0] D_FWD   = 2'b01;
  localparam logic [1:0] D_LEFT  = 2'b10;
  localparam logic [1:0] D_RIGHT = 2'b11;
  typedef enum logic [2:0] {TRACK, STOP, TURN, PASS, FAULT} state_t;
endpackage

// File: rtl/avoid_timer.sv
// avoid_timer: tick-enabled counter with clear and saturation at lim
// Ports: clk, rst (sync active-low), clr (clear, wins over inc), inc (count enable),
//        lim (terminal value), hit (count is at lim, or reaches it on this edge)
module avoid_timer
  import avoid_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [TW-1:0] lim,
  output logic          hit
);
  logic [TW-1:0] cnt;
  // hit looks one edge ahead so the phase ends on the tick that reaches lim
  assign hit = (cnt == lim) | (inc & (cnt == lim - 1'b1));
  always_ff @(posedge clk)
    if (!rst || clr) cnt <= '0;
    else if (inc && cnt != lim) cnt <= cnt + 1'b1;
endmodule

// File: rtl/avoid_sequencer.sv
// avoid_sequencer: obstacle-avoidance state machine overriding the tracking motor command
// Ports: clk, rst (sync active-low), led0/led1 (left/right obstacle sensors),
//        flag1 (avoidance enable), tick (timebase strobe), dianji0 (tracking command),
//        dianji (motor command), led2 (tracking), led3 (avoiding/fault), busy (not tracking)
module avoid_sequencer
  import avoid_sequencer_pkg::*;
#(
  parameter int DEB_N     = DEB_N_DEF,
  parameter int STOP_T    = STOP_T_DEF,
  parameter int TURN_T    = TURN_T_DEF,
  parameter int PASS_T    = PASS_T_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led0,
  input  logic       led1,
  input  logic       flag1,
  input  logic       tick,
  input  logic [1:0] dianji0,
  output logic [1:0] dianji,
  output logic       led2,
  output logic       led3,
  output logic       busy
);
  state_t state, nxt;
  logic obs, deb_hit, ph_hit, deb_inc, deb_clr, ph_clr, in_phase;
  logic [3:0] retry;
  logic [1:0] dir, dianji_d;
  logic [TW-1:0] ph_lim;
  assign obs      = led0 | led1;
  assign in_phase = (state == STOP) | (state == TURN) | (state == PASS);
  // one counter serves as obstacle debounce in TRACK and as clear counter in FAULT
  assign deb_inc  = tick & ((state == FAULT) ? ~obs : obs);
  assign deb_clr  = ((state == FAULT) ? obs : ~obs) | ~flag1 | in_phase | (nxt != state);
  assign ph_clr   = ~in_phase | (nxt != state);
  assign ph_lim   = (state == STOP) ? TW'(STOP_T) : (state == TURN) ? TW'(TURN_T) : TW'(PASS_T);
  avoid_timer u_deb (.clk(clk), .rst(rst), .clr(deb_clr), .inc(deb_inc), .lim(TW'(DEB_N)), .hit(deb_hit));
  avoid_timer u_ph  (.clk(clk), .rst(rst), .clr(ph_clr),  .inc(tick),    .lim(ph_lim),      .hit(ph_hit));
  always_ff @(posedge clk)
    if (!rst) state <= TRACK;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state == TRACK) nxt = (flag1 && deb_hit) ? STOP : TRACK;
    else if (!flag1) nxt = TRACK;
    else if (state == STOP) nxt = ph_hit ? TURN : STOP;
    else if (state == TURN) nxt = ph_hit ? PASS : TURN;
    else if (state == PASS) nxt = !ph_hit ? PASS : !obs ? TRACK : (int'(retry) < MAX_RETRY) ? STOP : FAULT;
    else nxt = deb_hit ? TRACK : FAULT;
  end
  always_comb begin
    dianji_d = (nxt == TRACK) ? dianji0 : (nxt == TURN) ? dir : (nxt == PASS) ? D_FWD : D_STOP;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      dianji <= D_STOP;
      led2   <= 1'b0;
      led3   <= 1'b0;
      busy   <= 1'b0;
      dir    <= D_RIGHT;
      retry  <= '0;
    end else begin
      dianji <= dianji_d;
      led2   <= nxt == TRACK;
      led3   <= nxt != TRACK;
      busy   <= nxt != TRACK;
      dir    <= (nxt == STOP && state != STOP) ? ((led1 && !led0) ? D_LEFT : D_RIGHT) : dir;
      retry  <= (nxt == STOP && state == PASS) ? retry + 1'b1 : ((nxt == STOP && state == TRACK) || !flag1) ? 4'd0 : retry;
    end
endmodule
